// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: derives pixel position from sync edges, fetches framebuffer pixels and drives aligned RGB/DE/syncs
module vga_pixel_pipe #(
    parameter int H_START  = 143,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              H_SYNC,
    input  logic              V_SYNC,
    input  logic              PATTERN_EN,
    output logic              FB_RD,
    output logic [ADDR_W-1:0] FB_ADDR,
    input  logic [7:0]        FB_DATA,
    output logic [2:0]        RED,
    output logic [2:0]        GRN,
    output logic [1:0]        BLU,
    output logic              DE,
    output logic              H_SYNC_OUT,
    output logic              V_SYNC_OUT
);
    localparam logic [10:0] X_LO     = 11'(H_START);
    localparam logic [10:0] X_HI     = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  Y_LO     = 10'(V_START);
    localparam logic [9:0]  Y_HI     = 10'(V_START + V_ACTIVE);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

    logic              h_prev, v_prev, h_fall, v_fall, vis, pat_q, pat_c;
    logic [10:0]       x_q, x_c, bc_q, bc_c;
    logic [9:0]        y_q, y_c;
    logic [2:0]        k_q, k_c, k_out;
    logic [ADDR_W-1:0] addr_q, addr_c;
    logic [RD_LAT:0]   vis_d, pat_d;
    logic [RD_LAT:0][2:0] k_d;
    logic [RD_LAT+1:0] hs_d, vs_d;

    // Position, bar index, address and frame mode of the pixel whose syncs are sampled this cycle
    always_comb begin
        h_fall = h_prev & ~H_SYNC;
        v_fall = v_prev & ~V_SYNC;
        x_c    = h_fall ? '0 : (&x_q ? x_q : x_q + 11'd1);
        y_c    = v_fall ? '0 : h_fall ? (&y_q ? y_q : y_q + 10'd1) : y_q;
        vis    = (x_c >= X_LO) && (x_c < X_HI) && (y_c >= Y_LO) && (y_c < Y_HI);
        addr_c = v_fall ? '0 : addr_q;
        pat_c  = v_fall ? PATTERN_EN : pat_q;
        bc_c   = (x_c == X_LO || bc_q == BAR_LAST) ? '0 : bc_q + 11'd1;
        k_c    = (x_c == X_LO) ? '0 : (bc_q == BAR_LAST) ? k_q + 3'd1 : k_q;
    end

    // Counters, frame-mode latch and the framebuffer read request
    always_ff @(posedge CLK) begin
        if (RST) begin
            h_prev  <= 1'b0;
            v_prev  <= 1'b0;
            x_q     <= '1;
            y_q     <= '1;
            addr_q  <= '0;
            pat_q   <= 1'b0;
            bc_q    <= '0;
            k_q     <= '0;
            FB_RD   <= 1'b0;
            FB_ADDR <= '0;
        end else begin
            h_prev  <= H_SYNC;
            v_prev  <= V_SYNC;
            x_q     <= x_c;
            y_q     <= y_c;
            addr_q  <= addr_c + ADDR_W'(vis);
            pat_q   <= pat_c;
            bc_q    <= bc_c;
            k_q     <= k_c;
            FB_RD   <= vis & ~pat_c;
            FB_ADDR <= addr_c;
        end
    end

    // Carry pixel attributes alongside the read latency and delay the syncs to match the RGB output
    always_ff @(posedge CLK) begin
        if (RST) begin
            vis_d <= '0;
            pat_d <= '0;
            k_d   <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
        end else begin
            vis_d <= {vis_d[RD_LAT-1:0], vis};
            pat_d <= {pat_d[RD_LAT-1:0], pat_c};
            k_d   <= {k_d[RD_LAT-1:0], k_c};
            hs_d  <= {hs_d[RD_LAT:0], H_SYNC};
            vs_d  <= {vs_d[RD_LAT:0], V_SYNC};
        end
    end

    assign k_out      = k_d[RD_LAT];
    assign H_SYNC_OUT = hs_d[RD_LAT+1];
    assign V_SYNC_OUT = vs_d[RD_LAT+1];

    // Registered DAC output; blanked pixels are forced to black
    always_ff @(posedge CLK) begin
        if (RST) begin
            DE              <= 1'b0;
            {RED, GRN, BLU} <= '0;
        end else begin
            DE              <= vis_d[RD_LAT];
            {RED, GRN, BLU} <= !vis_d[RD_LAT] ? 8'h00 :
                               pat_d[RD_LAT] ? {{3{k_out[2]}}, {3{k_out[1]}}, {2{k_out[0]}}} : FB_DATA;
        end
    end
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: scoreboard bench driving reduced-height frames through vga_pixel_pipe
module tb_vga_pixel_pipe;
    logic        clk = 0, rst = 1, h_sync = 1, v_sync = 1, pattern_en = 0;
    logic        fb_rd, de, h_out, v_out;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data, d1 = 0, d2 = 0;
    logic [2:0]  red, grn;
    logic [1:0]  blu;
    logic        fb_ff = 0, mon_en = 0, skip_run = 0, ho_prev = 1;
    logic [4:0]  h_hist = '1, v_hist = '1;
    logic [7:0]  exp_q[$];
    int          addr_q[$];
    logic [7:0]  rec[640];
    int compared = 0, mismatched = 0;
    int frame_rd = 0, rec_n = 0, first_addr = -1, last_addr = -1, de_run = 0, ho_x = 0;

    always #5 clk = ~clk;

    vga_pixel_pipe #(.V_START(3), .V_ACTIVE(4)) dut (
        .CLK(clk), .RST(rst), .H_SYNC(h_sync), .V_SYNC(v_sync), .PATTERN_EN(pattern_en),
        .FB_RD(fb_rd), .FB_ADDR(fb_addr), .FB_DATA(fb_data),
        .RED(red), .GRN(grn), .BLU(blu), .DE(de), .H_SYNC_OUT(h_out), .V_SYNC_OUT(v_out)
    );

    // framebuffer model: data = addr[7:0], two clocks after the request
    assign fb_data = fb_ff ? 8'hFF : d2;
    always @(posedge clk) begin
        d1 <= fb_addr[7:0];
        d2 <= d1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: sync delay, blanking, DE timing and scoreboard pops
    always @(negedge clk) if (mon_en) begin
        chk("h_sync_out", h_out, h_hist[3]);
        chk("v_sync_out", v_out, v_hist[3]);
        h_hist = {h_hist[3:0], h_sync};
        v_hist = {v_hist[3:0], v_sync};
        ho_x = (ho_prev && !h_out) ? 0 : ho_x + 1;
        ho_prev = h_out;
        if (!de) chk("blank_rgb", {red, grn, blu}, 0);
        if (de) begin
            if (de_run == 0) chk("de_start_col", ho_x, 143);
            de_run++;
            if (exp_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL pixel_unexpected: got rgb %02h with DE=1, expected no pixel", {red, grn, blu});
            end else chk("pixel_rgb", {red, grn, blu}, exp_q.pop_front());
            if (rec_n < 640) begin
                rec[rec_n] = {red, grn, blu};
                rec_n++;
            end
        end else if (de_run != 0) begin
            if (!skip_run) chk("de_run_len", de_run, 640);
            skip_run = 0;
            de_run = 0;
        end
        if (fb_rd) begin
            frame_rd++;
            if (first_addr < 0) first_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            if (addr_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL rd_unexpected: got FB_RD=1 addr %0d, expected no read", fb_addr);
            end else chk("fb_addr", fb_addr, addr_q.pop_front());
        end
    end

    // one 800x8 frame: hsync low 96 clocks, vsync low 2 lines, visible lines 3..6, columns 143..782
    task automatic run_frame(input logic pat, input logic tog, input logic ff, input int rst_line, input int rst_col);
        logic       pat_lat = 0, dead = 0;
        logic [2:0] kk;
        int         col, a;
        fb_ff = ff;
        pattern_en = pat;
        frame_rd = 0;
        rec_n = 0;
        first_addr = -1;
        for (int l = 0; l < 8; l++) begin
            for (int c = 0; c < 800; c++) begin
                @(posedge clk);
                #1;
                h_sync = (c >= 96);
                v_sync = (l >= 2);
                if (l == 0 && c == 0) pat_lat = pattern_en;
                if (tog && l == 4 && c == 0) pattern_en = ~pattern_en;
                rst = (l == rst_line && c == rst_col);
                if (rst) begin
                    dead = 1;
                    skip_run = 1;
                    repeat (3) if (exp_q.size() > 0) void'(exp_q.pop_back());
                end else if (!dead && l >= 3 && l < 7 && c >= 143 && c < 783) begin
                    col = c - 143;
                    a = (l - 3) * 640 + col;
                    kk = 3'(col / 80);
                    exp_q.push_back(pat_lat ? {{3{kk[2]}}, {3{kk[1]}}, {2{kk[0]}}} : ff ? 8'hFF : 8'(a));
                    if (!pat_lat) addr_q.push_back(a);
                end
                if (l == rst_line && c == rst_col + 1) begin
                    #2;
                    chk("rst_midline_out", {de, red, grn, blu, h_out, v_out, fb_rd}, 12'b000000000110);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_state", {de, red, grn, blu, h_out, v_out, fb_rd, fb_addr == 0}, 13'b0000000001101);
        @(posedge clk);
        #1;
        rst = 0;
        mon_en = 1;
        run_frame(0, 0, 0, -1, 0);
        chk("f0_rd_count", frame_rd, 2560);
        chk("f0_first_addr", first_addr, 0);
        chk("f0_last_addr", last_addr, 2559);
        chk("f0_pix0", rec[0], 8'h00);
        chk("f0_pix4", rec[4], 8'h04);
        run_frame(0, 0, 0, -1, 0);
        chk("f1_first_addr", first_addr, 0);
        chk("f1_rd_count", frame_rd, 2560);
        run_frame(1, 1, 0, -1, 0);
        chk("pat_rd_count", frame_rd, 0);
        chk("pat_pix0", rec[0], 8'h00);
        chk("pat_pix79", rec[79], 8'h00);
        chk("pat_pix80", rec[80], 8'h03);
        chk("pat_pix159", rec[159], 8'h03);
        chk("pat_pix559", rec[559], 8'hFC);
        chk("pat_pix560", rec[560], 8'hFF);
        chk("pat_pix639", rec[639], 8'hFF);
        run_frame(0, 0, 1, -1, 0);
        chk("ff_pix0", rec[0], 8'hFF);
        chk("ff_rd_count", frame_rd, 2560);
        run_frame(0, 0, 0, 4, 300);
        chk("rst_rd_count", frame_rd, 797);
        run_frame(0, 0, 0, -1, 0);
        chk("post_rst_rd_count", frame_rd, 2560);
        chk("post_rst_first_addr", first_addr, 0);
        chk("post_rst_pix4", rec[4], 8'h04);
        repeat (10) @(posedge clk);
        #2;
        chk("pixels_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
